masked_subbytes_sequencer: RTL and testbench

//  Initiator side of the shared masked S-box port. Accepts one masked NUM_BYTES-byte state.

---
 rtl/masked_subbytes_sequencer_pkg.sv | 33 +++
 rtl/masked_subbytes_sequencer_tag_pipe.sv | 49 ++++
 rtl/masked_subbytes_sequencer.sv | 159 +++++++++++++++
 tb/tb_masked_subbytes_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/masked_subbytes_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : masked_subbytes_sequencer_pkg
//  Description : Shared types and helpers for the masked SubBytes sequencer:
//                byte type, sequencer FSM encoding, randomness sizing.
//  Revision    : 1.0 - initial release
// ============================================================================
package masked_subbytes_sequencer_pkg;

  typedef logic [7:0] bv8_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } subbytes_seq_state_t;

  // Fresh random bits one masked GF(2^8) inversion consumes: one 18-bit
  // refresh group per share pair. Never zero, so the port always exists.
  function automatic int num_inv_random(input int ns);
    int pairs;
    pairs = (ns * (ns - 1)) / 2;
    return (pairs == 0) ? 1 : 18 * pairs;
  endfunction

  // Width of a byte index; at least one bit so single-byte jobs still work.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/masked_subbytes_sequencer_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : sbox_tag_pipe
//  Description : Shift register of {valid, idx} tags that tracks bytes in
//                flight through the fixed-latency external S-box.
//  Revision    : 1.0 - initial release
// ============================================================================
module sbox_tag_pipe #(
  parameter int LATENCY = 3,
  parameter int IDX_W   = 4
) (
  input  logic             in_clock,
  input  logic             in_reset,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  logic [LATENCY-1:0] valid_q, valid_d;
  logic [IDX_W-1:0]   idx_q [LATENCY];
  logic [IDX_W-1:0]   idx_d [LATENCY];

  // Next-stage values: new tag enters stage 0, every stage shifts by one.
  always_comb begin
    valid_d[0] = in_valid;
    idx_d[0]   = in_idx;
    for (int i = 1; i < LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      idx_d[i]   = idx_q[i-1];
    end
  end

  // Tag registers; reset drops every in-flight tag so late results are ignored.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      valid_q <= '0;
      idx_q   <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_idx   = idx_q[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/masked_subbytes_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : masked_subbytes_sequencer
//  Description : Streams the bytes of one masked state through a shared,
//                pipelined masked S-box and returns the substituted state
//                over a valid/ready handshake. Shares are never combined.
//  Config      : MASKED_SUBBYTES_ZEROIZE_EN - clear input/result registers on
//                handoff and blank the S-box input outside FEED.
//  Revision    : 1.0 - initial release
// ============================================================================
module masked_subbytes_sequencer
  import masked_subbytes_sequencer_pkg::*;
#(
  parameter  int NUM_SHARES   = 2,
  parameter  int NUM_BYTES    = 16,
  parameter  int SBOX_LATENCY = 3,
  localparam int NUM_RANDOM   = num_inv_random(NUM_SHARES)
) (
  input  logic                                    in_clock,
  input  logic                                    in_reset,
  input  logic                                    in_valid,
  output logic                                    out_ready,
  input  bv8_t [NUM_BYTES-1:0][NUM_SHARES-1:0]    in_state,
  input  logic                                    in_enc,
  input  logic [NUM_RANDOM-1:0]                   in_random,
  output logic                                    out_valid,
  input  logic                                    in_ready,
  output bv8_t [NUM_BYTES-1:0][NUM_SHARES-1:0]    out_state,
  output bv8_t [NUM_SHARES-1:0]                   out_sbox_a,
  output logic                                    out_sbox_enc,
  output logic [NUM_RANDOM-1:0]                   out_sbox_random,
  input  bv8_t [NUM_SHARES-1:0]                   in_sbox_b
);

  localparam int IDX_W = idx_width(NUM_BYTES);
  typedef logic [IDX_W-1:0] byte_idx_t;
  typedef bv8_t [NUM_BYTES-1:0][NUM_SHARES-1:0] job_state_t;
  localparam byte_idx_t LAST_IDX = byte_idx_t'(NUM_BYTES - 1);

  subbytes_seq_state_t state_q, state_d;
  byte_idx_t           cnt_q, cnt_d;
  job_state_t          in_q, in_d;
  job_state_t          res_q, res_d;
  logic                enc_q, enc_d;
  logic                out_valid_q, out_valid_d;
  logic                out_ready_q, out_ready_d;

  logic                push_valid;
  logic                tag_valid;
  byte_idx_t           tag_idx;

  sbox_tag_pipe #(
    .LATENCY (SBOX_LATENCY),
    .IDX_W   (IDX_W)
  ) u_tag_pipe (
    .in_clock  (in_clock),
    .in_reset  (in_reset),
    .in_valid  (push_valid),
    .in_idx    (cnt_q),
    .out_valid (tag_valid),
    .out_idx   (tag_idx)
  );

  // Sequencer next-state: accept, issue one byte per cycle, drain, hand off.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_d        = in_q;
    enc_d       = enc_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    out_ready_d = out_ready_q;
    push_valid  = 1'b0;

    // Capture runs independently of issue; a tag only exists for FEED issues.
    if (tag_valid) begin
      res_d[tag_idx] = in_sbox_b;
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_d        = in_state;
          enc_d       = in_enc;
          cnt_d       = '0;
          out_ready_d = 1'b0;
          state_d     = FEED;
        end
      end
      FEED: begin
        push_valid = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (tag_valid && (tag_idx == LAST_IDX)) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (in_ready) begin
          out_valid_d = 1'b0;
          out_ready_d = 1'b1;
          state_d     = IDLE;
`ifdef MASKED_SUBBYTES_ZEROIZE_EN
          in_d        = '0;
          res_d       = '0;
          enc_d       = 1'b0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_q        <= '0;
      res_q       <= '0;
      enc_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_q        <= in_d;
      res_q       <= res_d;
      enc_q       <= enc_d;
      out_valid_q <= out_valid_d;
      out_ready_q <= out_ready_d;
    end
  end

  // S-box operand: the currently addressed byte, blanked outside FEED if zeroizing.
  always_comb begin
`ifdef MASKED_SUBBYTES_ZEROIZE_EN
    out_sbox_a = (state_q == FEED) ? in_q[cnt_q] : '0;
`else
    out_sbox_a = in_q[cnt_q];
`endif
  end

  assign out_ready       = out_ready_q;
  assign out_valid       = out_valid_q;
  assign out_state       = res_q;
  assign out_sbox_enc    = enc_q;
  assign out_sbox_random = in_random;

endmodule
`default_nettype wire

// File: tb/tb_masked_subbytes_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_masked_subbytes_sequencer
//  Description : Self-checking bench: randomised jobs, masked S-box model,
//                scoreboard queue of expected recombined results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_masked_subbytes_sequencer;
  import masked_subbytes_sequencer_pkg::*;

  localparam int NS  = 2;
  localparam int NB  = 16;
  localparam int LAT = 3;
  localparam int NR  = num_inv_random(NS);

  typedef logic [NR-1:0]           rnd_t;
  typedef bv8_t [NB-1:0][NS-1:0]   st_t;
  typedef bv8_t [NB-1:0]           plain_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, out_ready, out_valid, in_ready, in_enc, sbox_enc;
  st_t            in_state, out_state;
  rnd_t           in_random, sbox_random;
  bv8_t [NS-1:0]  sbox_a, sbox_b;

  masked_subbytes_sequencer #(
    .NUM_SHARES   (NS),
    .NUM_BYTES    (NB),
    .SBOX_LATENCY (LAT)
  ) dut (
    .in_clock        (clk),
    .in_reset        (rst),
    .in_valid        (in_valid),
    .out_ready       (out_ready),
    .in_state        (in_state),
    .in_enc          (in_enc),
    .in_random       (in_random),
    .out_valid       (out_valid),
    .in_ready        (in_ready),
    .out_state       (out_state),
    .out_sbox_a      (sbox_a),
    .out_sbox_enc    (sbox_enc),
    .out_sbox_random (sbox_random),
    .in_sbox_b       (sbox_b)
  );

  always #5 clk = ~clk;

  int     cyc = 0;
  int     n_cmp = 0;
  int     n_fail = 0;
  bv8_t   sbox_tab [256];
  bv8_t   inv_tab  [256];
  plain_t exp_q [$];
  int     acc_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- AES S-box from GF(2^8) arithmetic ----------------
  function automatic bv8_t gmul(input bv8_t a, input bv8_t b);
    bv8_t p;
    bv8_t aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  function automatic bv8_t rotl(input bv8_t x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic bv8_t sbox_math(input bv8_t x);
    bv8_t v;
    v = 8'h01;
    for (int i = 0; i < 254; i++) v = gmul(v, x);
    return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
  endfunction

  function automatic plain_t ref_job(input st_t s, input logic enc);
    plain_t r;
    bv8_t   x;
    for (int i = 0; i < NB; i++) begin
      x = 8'h00;
      for (int k = 0; k < NS; k++) x = x ^ s[i][k];
      r[i] = enc ? sbox_tab[x] : inv_tab[x];
    end
    return r;
  endfunction

  function automatic plain_t recombine(input st_t s);
    plain_t r;
    for (int i = 0; i < NB; i++) begin
      r[i] = 8'h00;
      for (int k = 0; k < NS; k++) r[i] = r[i] ^ s[i][k];
    end
    return r;
  endfunction

  function automatic st_t rand_state();
    st_t s;
    for (int i = 0; i < NB; i++)
      for (int k = 0; k < NS; k++) s[i][k] = bv8_t'($urandom);
    return s;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- external masked S-box model, LAT cycles deep ----------------
  bv8_t [NS-1:0] sb_pipe [LAT];
  always @(posedge clk) begin : sbox_model
    bv8_t          x;
    bv8_t          y;
    bv8_t [NS-1:0] o;
    x = 8'h00;
    for (int k = 0; k < NS; k++) x = x ^ sbox_a[k];
    y = sbox_enc ? sbox_tab[x] : inv_tab[x];
    for (int k = 1; k < NS; k++) begin
      o[k] = bv8_t'($urandom);
      y    = y ^ o[k];
    end
    o[0] = y;
    sb_pipe[0] <= o;
    for (int j = 1; j < LAT; j++) sb_pipe[j] <= sb_pipe[j-1];
  end
  assign sbox_b = sb_pipe[LAT-1];

  // ---------------- scoreboard push on accepted job ----------------
  always @(posedge clk) begin
    if (!rst && in_valid && out_ready) begin
      exp_q.push_back(ref_job(in_state, in_enc));
      acc_q.push_back(cyc);
    end
  end

  // ---------------- monitor ----------------
  logic   prev_valid = 1'b0;
  logic   prev_hs    = 1'b0;
  st_t    prev_state;
  plain_t exp_r;
  int     acc_c;
  always @(negedge clk) begin
    if (!rst) begin
      check("random_passthrough", 128'(sbox_random), 128'(in_random));
      if (out_valid && !prev_valid) begin
        if (acc_q.size() == 0) check("unexpected_valid", 128'(1), 128'(0));
        else check("latency", 128'(cyc - acc_q[0]), 128'(NB + LAT + 1));
      end
      if (out_valid && prev_valid) begin
        check("done_state_stable", out_state, prev_state);
        check("done_ready_low", 128'(out_ready), 128'(0));
      end
`ifdef MASKED_SUBBYTES_ZEROIZE_EN
      if (prev_hs) check("zeroized_result", out_state, 128'(0));
`endif
      if (out_valid && in_ready) begin
        if (exp_q.size() == 0) begin
          check("result_without_job", 128'(1), 128'(0));
        end else begin
          exp_r = exp_q.pop_front();
          acc_c = acc_q.pop_front();
          check("result_data", recombine(out_state), exp_r);
        end
      end
      prev_hs = out_valid && in_ready;
    end else begin
      prev_hs = 1'b0;
    end
    prev_valid = out_valid;
    prev_state = out_state;
  end

  // ---------------- randomness driver ----------------
  initial begin
    in_random = '0;
    forever begin
      @(posedge clk);
      #1;
      in_random = rnd_t'($urandom);
    end
  end

  // ---------------- job driver ----------------
  task automatic wait_done(input int stall, input logic offer_in_done);
    int k;
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid) begin
      check("done_timeout", 128'(0), 128'(1));
      return;
    end
    @(posedge clk);
    #1;
    if (offer_in_done) begin
      in_valid = 1'b1;
      in_state = rand_state();
      in_enc   = 1'b1;
    end
    repeat (stall) @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_ready = 1'b1;
    @(posedge clk);
    #1;
    in_ready = 1'b0;
  endtask

  task automatic offer(input st_t s, input logic enc, output logic ok);
    int k;
    @(posedge clk);
    #1;
    in_state = s;
    in_enc   = enc;
    in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!out_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    ok = out_ready;
    if (!ok) check("accept_timeout", 128'(0), 128'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_state = rand_state();
    in_enc   = ($urandom_range(0, 1) == 1);
  endtask

  task automatic run_job(input st_t s, input logic enc, input int stall, input logic offer_in_done);
    logic ok;
    offer(s, enc, ok);
    if (ok) wait_done(stall, offer_in_done);
  endtask

  initial begin : main
    st_t  s;
    bv8_t r;
    logic ok;

    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_math(bv8_t'(i));
    for (int i = 0; i < 256; i++) inv_tab[sbox_tab[i]] = bv8_t'(i);

    rst      = 1'b1;
    in_valid = 1'b0;
    in_ready = 1'b0;
    in_enc   = 1'b0;
    in_state = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", 128'(out_ready), 128'(1));
    check("reset_valid", 128'(out_valid), 128'(0));
    check("reset_state", out_state, 128'(0));
    check("reset_enc", 128'(sbox_enc), 128'(0));

    // Forward S-box of bytes 0x00..0x0F, share1 zero.
    for (int i = 0; i < NB; i++) begin
      s[i][0] = bv8_t'(i);
      s[i][1] = 8'h00;
    end
    run_job(s, 1'b1, 0, 1'b0);

    // Inverse of 0x63 everywhere, random share split.
    for (int i = 0; i < NB; i++) begin
      r = bv8_t'($urandom);
      s[i][1] = r;
      s[i][0] = 8'h63 ^ r;
    end
    run_job(s, 1'b0, 0, 1'b0);

    // Consumer stalls 10 cycles in DONE while a new job is offered.
    run_job(rand_state(), 1'b1, 10, 1'b1);

    // Reset during cycle 8 of a job.
    offer(rand_state(), 1'b1, ok);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    check("midreset_valid", 128'(out_valid), 128'(0));
    check("midreset_ready", 128'(out_ready), 128'(1));
    run_job(rand_state(), 1'b0, 1, 1'b0);

    // Randomised jobs.
    for (int j = 0; j < 8; j++)
      run_job(rand_state(), ($urandom_range(0, 1) == 1), $urandom_range(0, 3), 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
